// File: rtl/uart_tx_fifo_param_pkg.sv
// uart_tx_fifo_param_pkg: shared FSM state, parity mode types and defaults for the UART TX path
package uart_tx_fifo_param_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  // Mode 3 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return mode == PAR_EVEN || mode == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: single-clock FIFO, no fall-through
//   clk, rst       : clock, async active-high reset (flushes contents)
//   push, din      : write request and data (ignored when full)
//   pop, dout      : read request and head word (dout valid while !empty)
//   full, empty    : occupancy flags derived from count
//   count          : entries held, 0..DEPTH
module uart_fifo_sync
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter with input FIFO and runtime parity/stop config
//   clk, rst             : clock, async active-high reset (drops any frame in flight)
//   din, din_valid       : host word and valid; accepted when din_ready
//   din_ready            : FIFO not full
//   parity_mode, stop2   : frame format, latched when a word is popped
//   tx                   : registered serial line, idle high
//   tx_busy, tx_done     : frame in progress / one-cycle end-of-frame pulse
//   fifo_count           : words queued
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS);
  tx_state_e state;
  logic [BW-1:0] baud;
  logic [NW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift, head;
  logic par_en, par_val, two_stop;
  logic full, empty, baud_end, last_stop, frame_end, pop;
  uart_fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (din_valid),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  assign din_ready = !full;
  assign baud_end  = baud == BW'(CLKS_PER_BIT - 1);
  // bit_cnt doubles as the stop-bit index inside STOP.
  assign last_stop = bit_cnt == NW'(two_stop);
  assign frame_end = state == STOP && last_stop && baud_end;
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop       = !empty && (state == IDLE || frame_end);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_val  <= 1'b0;
      two_stop <= 1'b0;
    end else begin
      baud    <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
      // Registered pulse: raised one cycle early so it lines up with the final stop cycle.
      tx_done <= state == STOP && last_stop && baud == BW'(CLKS_PER_BIT - 2);
      if (pop) begin
        state    <= START;
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        shift    <= head;
        bit_cnt  <= '0;
        par_en   <= parity_enabled(parity_mode);
        par_val  <= (^head) ^ (parity_mode == PAR_ODD);
        two_stop <= stop2;
      end else if (baud_end) begin
        case (state)
          START: begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == NW'(DATA_BITS - 1)) begin
              state   <= par_en ? PARITY : STOP;
              tx      <= par_en ? par_val : 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
          PARITY: begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
          STOP: begin
            if (last_stop) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
